main_host: RTL and testbench

MAIN_HOST -- requirements
Module: main_host

---
 rtl/main_host.sv | 162 ++++++++++++++++
 tb/tb_main_host.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/main_host.sv
// Host sequencer for an accelerator kernel: loads the kernel array, pulses start, waits for done/timeout, returns result.
// Optional array read-back after a successful run is enabled by defining MAIN_HOST_READBACK_EN.
module main_host #(
  parameter int DEPTH   = 1,
  parameter int ADDR_W  = 1,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [63:0]       start_init,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [63:0]       ld_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [63:0]       res_data,
  output logic              res_timeout,
`ifdef MAIN_HOST_READBACK_EN
  output logic              rb_valid,
  input  logic              rb_ready,
  output logic [63:0]       rb_data,
`endif
  output logic              r_enable,
  output logic [63:0]       init_i,
  input  logic              w_enable,
  input  logic [63:0]       result,
  output logic              controlArr,
  output logic              controlArrWEnable_a,
  output logic [ADDR_W-1:0] controlArrAddr_a,
  output logic [63:0]       controlArrWData_a,
  input  logic [63:0]       controlArrRData_a
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [TW-1:0]     TLAST = TW'(TIMEOUT - 1);

`ifdef MAIN_HOST_READBACK_EN
  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, READBACK, RESULT} state_e;
`else
  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, RESULT} state_e;
`endif

  state_e            state;
  logic [ADDR_W-1:0] cnt;
  logic [TW-1:0]     tcnt;
  logic [63:0]       init_q;
  logic [63:0]       res_q;
  logic              rb_rd;

`ifdef MAIN_HOST_READBACK_EN
  logic              rb_wait;
  logic [63:0]       rb_q;
  assign rb_data = rb_q;
`else
  // Array read data is only consumed by the read-back path.
  logic unused_rdata;
  assign unused_rdata = ^controlArrRData_a;
  assign rb_rd = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      tcnt        <= '0;
      init_q      <= '0;
      res_q       <= '0;
      start_ready <= 1'b1;
      ld_ready    <= 1'b0;
      r_enable    <= 1'b0;
      res_valid   <= 1'b0;
      res_timeout <= 1'b0;
`ifdef MAIN_HOST_READBACK_EN
      rb_rd       <= 1'b0;
      rb_wait     <= 1'b0;
      rb_valid    <= 1'b0;
      rb_q        <= '0;
`endif
    end else begin
      r_enable <= 1'b0;
      case (state)
        IDLE: if (start_valid) begin
          init_q      <= start_init;
          cnt         <= '0;
          start_ready <= 1'b0;
          ld_ready    <= 1'b1;
          state       <= LOAD;
        end
        LOAD: if (ld_valid) begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            ld_ready <= 1'b0;
            r_enable <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          tcnt  <= '0;
          state <= RUN;
        end
        // A done flag arriving on the last allowed cycle still wins over the timeout.
        RUN: if (w_enable) begin
          res_q       <= result;
          res_timeout <= 1'b0;
`ifdef MAIN_HOST_READBACK_EN
          cnt         <= '0;
          rb_rd       <= 1'b1;
          state       <= READBACK;
`else
          res_valid   <= 1'b1;
          state       <= RESULT;
`endif
        end else if (tcnt == TLAST) begin
          res_q       <= '0;
          res_timeout <= 1'b1;
          res_valid   <= 1'b1;
          state       <= RESULT;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
`ifdef MAIN_HOST_READBACK_EN
        READBACK: if (rb_rd) begin
          rb_rd   <= 1'b0;
          rb_wait <= 1'b1;
        end else if (rb_wait) begin
          rb_wait  <= 1'b0;
          rb_q     <= controlArrRData_a;
          rb_valid <= 1'b1;
        end else if (rb_valid && rb_ready) begin
          rb_valid <= 1'b0;
          if (cnt == LAST) begin
            res_valid <= 1'b1;
            state     <= RESULT;
          end else begin
            cnt   <= cnt + 1'b1;
            rb_rd <= 1'b1;
          end
        end
`endif
        RESULT: if (res_ready) begin
          res_valid   <= 1'b0;
          res_timeout <= 1'b0;
          start_ready <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ld_ready is high exactly while in LOAD, so it doubles as the load-phase qualifier.
  assign controlArr          = ld_ready | rb_rd;
  assign controlArrWEnable_a = ld_ready & ld_valid;
  assign controlArrAddr_a    = controlArr ? cnt : '0;
  assign controlArrWData_a   = ld_ready ? ld_data : '0;
  assign init_i              = r_enable ? init_q : '0;
  assign res_data            = res_q;

endmodule

// File: tb/tb_main_host.sv
// Self-checking bench for main_host: kernel/array stub plus a job-level reference model.
module tb_main_host;
  localparam int DEPTH = 4, ADDR_W = 2, TIMEOUT = 16;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        start_valid = 1'b0, start_ready;
  logic [63:0] start_init = '0;
  logic        ld_valid = 1'b0, ld_ready;
  logic [63:0] ld_data = '0;
  logic        res_valid, res_ready = 1'b0, res_timeout;
  logic [63:0] res_data;
  logic        r_enable, w_enable = 1'b0;
  logic [63:0] init_i, result = '0;
  logic        controlArr, controlArrWEnable_a;
  logic [ADDR_W-1:0] controlArrAddr_a;
  logic [63:0] controlArrWData_a, controlArrRData_a = '0;
  logic        rbv;
`ifdef MAIN_HOST_READBACK_EN
  logic        rb_valid, rb_ready = 1'b0;
  logic [63:0] rb_data;
  assign rbv = rb_valid;
`else
  assign rbv = 1'b0;
`endif

  int n_tests = 0, n_fail = 0;

  main_host #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready), .start_init(start_init),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_timeout(res_timeout),
`ifdef MAIN_HOST_READBACK_EN
    .rb_valid(rb_valid), .rb_ready(rb_ready), .rb_data(rb_data),
`endif
    .r_enable(r_enable), .init_i(init_i), .w_enable(w_enable), .result(result),
    .controlArr(controlArr), .controlArrWEnable_a(controlArrWEnable_a),
    .controlArrAddr_a(controlArrAddr_a), .controlArrWData_a(controlArrWData_a),
    .controlArrRData_a(controlArrRData_a)
  );

  always #5 clk = ~clk;

  // Reference kernel: doubles non-negative inits, triples the magnitude of negative ones.
  function automatic logic [63:0] kern(input logic [63:0] x);
    longint s;
    s = longint'(x);
    return (s < 0) ? 64'(-3 * s) : 64'(2 * s);
  endfunction

  // Array memory (one-cycle read latency) and kernel stub; the kernel leaves its result in word 0.
  logic [63:0] mem [DEPTH];
  int          wr_cnt = 0, pulses = 0, k_cnt = 0, k_lat = 3;
  bit          k_busy = 0, k_hang = 0;
  logic [63:0] k_init = '0;
  always @(posedge clk) begin
    if (controlArr && controlArrWEnable_a) begin
      mem[controlArrAddr_a] <= controlArrWData_a;
      wr_cnt <= wr_cnt + 1;
    end
    if (controlArr && !controlArrWEnable_a) controlArrRData_a <= mem[controlArrAddr_a];
    if (r_enable) begin
      w_enable <= 1'b0; k_busy <= 1'b1; k_cnt <= k_lat; k_init <= init_i; pulses <= pulses + 1;
    end else if (k_busy && !k_hang) begin
      if (k_cnt == 0) begin
        k_busy <= 1'b0; w_enable <= 1'b1; result <= kern(k_init); mem[0] <= kern(k_init);
      end else k_cnt <= k_cnt - 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_start_ready"}, start_ready, 1);
    chk({tag, "_ld_ready"}, ld_ready, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_timeout"}, res_timeout, 0);
    chk({tag, "_r_enable"}, r_enable, 0);
    chk({tag, "_ctrl"}, {controlArr, controlArrWEnable_a}, 0);
    chk({tag, "_addr_wdata"}, {62'(controlArrAddr_a), 2'b0} | controlArrWData_a, 0);
    chk({tag, "_rbv"}, rbv, 0);
  endtask

  // One job from the host's view; called right after a posedge+1.
  task automatic run_job(input logic [63:0] init, input logic [63:0] d0, input bit stall,
                         input bit hang, input bit abort);
    logic [63:0] d [DEPTH];
    logic [63:0] exp_res;
    int p0, w0, n;
    d[0] = d0;
    for (int k = 1; k < DEPTH; k++) d[k] = {$urandom, $urandom};
    k_hang = hang; k_lat = $urandom_range(1, 8);
    p0 = pulses;
    chk("idle_start_ready", start_ready, 1);
    start_valid = 1'b1; start_init = init;
    cyc();
    start_valid = 1'b0; start_init = '0;
    chk("load_ld_ready", ld_ready, 1);
    w0 = wr_cnt;
    for (int k = 0; k < DEPTH; k++) begin
      if (stall && k == 2) begin
        ld_valid = 1'b0;
        for (int s = 0; s < 3; s++) begin
          #1 chk("ld_stall_no_write", controlArrWEnable_a, 0);
          chk("ld_stall_addr", 64'(controlArrAddr_a), 2);
          cyc();
        end
        chk("ld_stall_writes", wr_cnt, w0 + 2);
      end
      ld_valid = 1'b1; ld_data = d[k];
      #1 chk("ld_addr", 64'(controlArrAddr_a), 64'(k));
      cyc();
    end
    ld_valid = 1'b0; ld_data = '0;
    chk("ld_writes", wr_cnt, w0 + DEPTH);
    chk("start_pulse", {r_enable, controlArr}, 2'b10);
    chk("start_init", init_i, init);
    cyc();
    chk("run_no_pulse", {r_enable, controlArr}, 0);
    if (abort) begin
      cyc(); cyc();
      #2 rst_n = 1'b0;
      #1 chk_reset_outs("async_rst");
      for (int s = 0; s < 3; s++) begin cyc(); chk("rst_no_res", {res_valid, rbv}, 0); end
      rst_n = 1'b1;
      chk("rst_pulses", pulses, p0 + 1);
      return;
    end
    n = 0;
    while (!(res_valid || rbv) && n < 100) begin cyc(); n++; end
    if (hang) begin
      chk("timeout_latency", n, TIMEOUT);
      exp_res = '0;
    end else begin
      chk("done_wait_bounded", n < 100, 1);
      exp_res = kern(init);
`ifdef MAIN_HOST_READBACK_EN
      for (int k = 0; k < DEPTH; k++) begin
        n = 0;
        while (!rb_valid && n < 20) begin cyc(); n++; end
        chk("rb_data", rb_data, (k == 0) ? exp_res : d[k]);
        chk("rb_before_res", res_valid, 0);
        if (stall && k == 1) begin
          for (int s = 0; s < 4; s++) begin
            cyc();
            chk("rb_stall_hold", {rb_valid, rb_data}, {1'b1, d[1]});
          end
        end
        rb_ready = 1'b1; cyc(); rb_ready = 1'b0;
        chk("rb_drop", rb_valid, 0);
      end
      n = 0;
      while (!res_valid && n < 20) begin cyc(); n++; end
`endif
    end
    chk("res_valid", res_valid, 1);
    chk("res_data", res_data, exp_res);
    chk("res_timeout", res_timeout, hang);
    chk("no_start_in_result", start_ready, 0);
    chk("one_pulse", pulses, p0 + 1);
    if (!res_ready) begin
      cyc();
      chk("res_hold", {res_valid, res_data}, {1'b1, exp_res});
      res_ready = 1'b1; cyc(); res_ready = 1'b0;
    end else cyc();
    chk("back_to_idle", {start_ready, res_valid}, 2'b10);
    k_hang = 0;
  endtask

  initial begin
    #12;
    chk_reset_outs("reset");
    chk("reset_res_data", res_data, 0);
    chk("reset_init_i", init_i, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    run_job(64'd5, 64'd7, 0, 0, 0);
    run_job(64'hFFFF_FFFF_FFFF_FFFC, {$urandom, $urandom}, 0, 0, 0);
    run_job({$urandom, $urandom}, {$urandom, $urandom}, 1, 0, 0);
    run_job(64'd9, 64'd1, 0, 1, 0);
    run_job(64'd11, 64'd2, 0, 0, 1);
    chk("post_rst_ready", start_ready, 1);
    run_job(64'd3, {$urandom, $urandom}, 0, 0, 0);
    res_ready = 1'b1;
    run_job(64'd5, {$urandom, $urandom}, 0, 0, 0);
    run_job(64'd1, {$urandom, $urandom}, 0, 0, 0);
    res_ready = 1'b0;
    for (int j = 0; j < 4; j++)
      run_job({$urandom, $urandom}, {$urandom, $urandom}, j[0], 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end
endmodule
